edge_pulse_debouncer: RTL

- Upstream conditioning stage for the decade counter datapath.
- Takes a raw, asynchronous, bouncy push-button/switch level (btn_in) and synchronises it into the clk domain.
- Debounces it with a stability counter and a 4-state FSM.
- Emits single-cycle rising/falling edge pulses; rise_pulse is the count-enable tick consumed by the downstream counter.

---
 rtl/edge_pulse_debouncer_pkg.sv | 15 +
 rtl/sync_2ff.sv | 23 ++
 rtl/edge_pulse_debouncer.sv | 102 ++++++++++
 3 files changed

// File: rtl/edge_pulse_debouncer_pkg.sv
// Shared types and defaults for the button conditioning stage.
// Reused by the counter-stage integration bench.
package edge_pulse_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } db_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 10;
  localparam int DEFAULT_CNT_W           = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Synchronous active-high reset clears both stages.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // first stage may go metastable; second stage gives it a cycle to settle
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/edge_pulse_debouncer.sv
// Synchronise, debounce and edge-detect a bouncy button level.
// rise_pulse is the one-cycle count enable for the decade counter.
module edge_pulse_debouncer
  import edge_pulse_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             samp;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             rise_nxt;
  logic             fall_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (samp)
  );

  // state, stability counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE_LOW;
      cnt        <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      level      <= level_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // next-state: any return to the old level drops all accumulated credit
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    level_nxt = level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    unique case (state)
      IDLE_LOW: begin
        if (samp) begin
          state_nxt = WAIT_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!samp) begin
          state_nxt = IDLE_LOW;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE_HIGH;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      IDLE_HIGH: begin
        if (!samp) begin
          state_nxt = WAIT_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      WAIT_LOW: begin
        if (samp) begin
          state_nxt = IDLE_HIGH;
        end else if (cnt == CNT_MAX) begin
          state_nxt = IDLE_LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE_LOW;
        level_nxt = 1'b0;
      end
    endcase
  end

endmodule
